// File: rtl/m_wbuart_if.sv
// Wishbone-style register bus between the midgetv core and the UART.
// The core side drives strobe/write/address/data and the UART returns read data and ack.
interface m_wbuart_if;
  logic        STB_I;
  logic        WE_I;
  logic        ADR_I;
  logic [7:0]  DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (output STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
  modport slave  (input STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/m_wbuart.sv
// Polled 8N1 UART with a fixed baud divisor behind a zero-wait Wishbone slave.
// The core moves whole bytes through the DATA register and polls the STATUS register.
module m_wbuart #(
  parameter int DIVISOR    = 104,
  parameter bit DAT_O_ZERO = 1'b1
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  m_wbuart_if.slave  wb,
  input  logic       usartRX,
  output logic       usartTX
);

  localparam logic [15:0] DIV_M1  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIVISOR / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_out_q, tx_out_d;

  logic [1:0]  rx_sync_q, rx_sync_d;
  state_t      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rxdata_q, rxdata_d;
  logic        rxvalid_q, rxvalid_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;

  logic        rd_data, wr_data, txbusy, rx_s, rx_store;
  logic [31:0] rd_mux;

  assign rd_data = wb.STB_I & ~wb.WE_I & ~wb.ADR_I;
  assign wr_data = wb.STB_I &  wb.WE_I & ~wb.ADR_I;
  assign txbusy  = (tx_state_q != S_IDLE);
  assign rx_s    = rx_sync_q[1];
  assign usartTX = tx_out_q;
  assign wb.ACK_O = wb.STB_I;

  // With DAT_O_ZERO the output is OR-merged on the core bus, so it must be 0 when not read
  always_comb begin
    rd_mux = wb.ADR_I ? {28'b0, ferr_q, ovr_q, txbusy, rxvalid_q} : {24'b0, rxdata_q};
    if (!DAT_O_ZERO || (wb.STB_I && !wb.WE_I)) wb.DAT_O = rd_mux;
    else                                       wb.DAT_O = 32'b0;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    case (tx_state_q)
      S_IDLE: begin
        if (wr_data) begin
          tx_state_d = S_START;
          tx_cnt_d   = 16'd0;
          tx_idx_d   = 3'd0;
          tx_shift_d = wb.DAT_I;
          tx_out_d   = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = 16'd0;
          tx_state_d = S_DATA;
          tx_out_d   = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = 16'd0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_out_d   = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = 16'd0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Receiver counts down to zero; the half-bit start wait lands later samples mid-bit
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], usartRX};
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_store   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (!rx_s) begin
            rx_state_d = S_DATA;
            rx_cnt_d   = DIV_M1;
            rx_idx_d   = 3'd0;
          end else begin
            rx_state_d = S_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = DIV_M1;
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_store   = 1'b1;
          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A store in the same cycle as a DATA read wins and does not count as an overrun
  always_comb begin
    rxdata_d  = rxdata_q;
    rxvalid_d = rxvalid_q;
    ovr_d     = ovr_q;
    ferr_d    = ferr_q;
    if (rd_data) begin
      rxvalid_d = 1'b0;
      ovr_d     = 1'b0;
      ferr_d    = 1'b0;
    end
    if (rx_store) begin
      rxdata_d  = rx_shift_q;
      rxvalid_d = 1'b1;
      ferr_d    = ~rx_s;
      if (rxvalid_q && !rd_data) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_out_q   <= 1'b1;
      rx_sync_q  <= 2'b11;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rxdata_q   <= 8'd0;
      rxvalid_q  <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rxdata_q   <= rxdata_d;
      rxvalid_q  <= rxvalid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule
